// File: rtl/bp_be_pkg.sv
// Shared back-end types for the stride detector: processor configs, confidence
// encodings and the per-PC stride table entry declared through a macro.
`define DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_mp, tag_width_mp, loop_range_mp) \
  typedef struct packed {                    \
    logic                      valid;        \
    logic [tag_width_mp-1:0]   tag;          \
    logic [vaddr_width_mp-1:0] last_addr;    \
    logic [vaddr_width_mp-1:0] stride;       \
    logic [1:0]                conf;         \
    logic [loop_range_mp-1:0]  quiet;        \
  } bp_be_stride_entry_s

package bp_be_pkg;

  typedef enum logic {e_bp_default_cfg = 1'b0} bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  localparam logic [1:0] e_conf_none = 2'd0;
  localparam logic [1:0] e_conf_low  = 2'd1;
  localparam logic [1:0] e_conf_mid  = 2'd2;
  localparam logic [1:0] e_conf_high = 2'd3;

endpackage

// File: rtl/bsg_one_fifo.sv
// Single-entry valid/ready buffer; accepts a new word in the same cycle the
// held word is dequeued.
module bsg_one_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               full_q;
  logic [width_p-1:0] data_q;

  assign ready_o = ~full_q | yumi_i;
  assign v_o     = full_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (v_i & ready_o) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (yumi_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Per-PC stride tracker: direct-mapped table of last address/stride/confidence,
// emitting one prefetch request per confirmed stride through a one-entry buffer.
module bp_be_stride_detector
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p       = e_bp_default_cfg,
  parameter int         entries_p         = 8,
  parameter int         tag_width_p       = 10,
  parameter int         stride_width_p    = 8,
  parameter int         loop_range_p      = 8,
  parameter int         prefetch_degree_p = 4,
  parameter int         conf_thresh_p     = 2,
  localparam int        vaddr_width_p     = bp_vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_v_i,
  input  logic [vaddr_width_p-1:0]  load_pc_i,
  input  logic [vaddr_width_p-1:0]  load_eff_addr_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
);

  localparam int lg_entries_lp = $clog2(entries_p);
  localparam int fifo_width_lp = 2*vaddr_width_p + stride_width_p;

  `DECLARE_BP_BE_STRIDE_ENTRY_S(vaddr_width_p, tag_width_p, loop_range_p);

  bp_be_stride_entry_s table_q [entries_p];
  bp_be_stride_entry_s entry_r, entry_d;

  logic [lg_entries_lp-1:0] idx;
  logic [tag_width_p-1:0]   tag;
  logic [vaddr_width_p-1:0] delta;
  logic                     hit, same_stride, eligible, trigger;
  logic                     fifo_ready, fifo_v;
  logic [fifo_width_lp-1:0] fifo_data;
  logic [1:0]               conf_next;

  assign idx     = load_pc_i[2 +: lg_entries_lp];
  assign tag     = load_pc_i[2+lg_entries_lp +: tag_width_p];
  assign entry_r = table_q[idx];

  assign hit         = entry_r.valid & (entry_r.tag == tag);
  assign delta       = load_eff_addr_i - entry_r.last_addr;
  assign same_stride = hit & (delta == entry_r.stride);
  assign eligible    = (delta != '0) & (delta[vaddr_width_p-1:stride_width_p] == '0);
  assign conf_next   = (entry_r.conf == e_conf_high) ? e_conf_high : entry_r.conf + 2'd1;

  // Quiet is checked before this cycle's decrement so the window covers exactly
  // prefetch_degree_p further loads.
  assign trigger = load_v_i & same_stride & eligible
                 & (int'(conf_next) >= conf_thresh_p) & (entry_r.quiet == '0);

  always_comb begin
    entry_d = entry_r;
    if (!hit) begin
      entry_d.valid     = 1'b1;
      entry_d.tag       = tag;
      entry_d.last_addr = load_eff_addr_i;
      entry_d.stride    = '0;
      entry_d.conf      = e_conf_none;
      entry_d.quiet     = '0;
    end else if (same_stride) begin
      entry_d.last_addr = load_eff_addr_i;
      entry_d.conf      = conf_next;
      if (trigger & fifo_ready)
        entry_d.quiet = loop_range_p'(prefetch_degree_p);
      else if (entry_r.quiet != '0)
        entry_d.quiet = entry_r.quiet - 1'b1;
    end else begin
      entry_d.last_addr = load_eff_addr_i;
      entry_d.stride    = delta;
      entry_d.conf      = e_conf_none;
      entry_d.quiet     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < entries_p; i++) table_q[i] <= '0;
    end else if (load_v_i) begin
      table_q[idx] <= entry_d;
    end
  end

  bsg_one_fifo #(.width_p(fifo_width_lp)) out_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(fifo_ready),
    .data_i ({load_pc_i, load_eff_addr_i, delta[stride_width_p-1:0]}),
    .v_i    (trigger),
    .v_o    (fifo_v),
    .data_o (fifo_data),
    .yumi_i (fifo_v & ready_and_i)
  );

  assign v_o                            = fifo_v;
  assign {pc_o, eff_addr_o, stride_o}   = fifo_data;
  assign loop_counter_o                 = loop_range_p'(prefetch_degree_p);

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed bench for the stride detector: confirmation, quiet window,
// back-pressure drop, ineligible strides, aliasing, stride change, reset.
module tb_bp_be_stride_detector;
  import bp_be_pkg::*;

  localparam int VW = 39;

  logic          clk_i = 1'b0;
  logic          reset_i, load_v_i, ready_and_i, v_o;
  logic [VW-1:0] load_pc_i, load_eff_addr_i, pc_o, eff_addr_o;
  logic [7:0]    stride_o, loop_counter_o;

  int tests_run = 0, tests_failed = 0, xfers = 0, base;

  always #5 clk_i = ~clk_i;

  bp_be_stride_detector dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .load_v_i       (load_v_i),
    .load_pc_i      (load_pc_i),
    .load_eff_addr_i(load_eff_addr_i),
    .v_o            (v_o),
    .ready_and_i    (ready_and_i),
    .pc_o           (pc_o),
    .eff_addr_o     (eff_addr_o),
    .stride_o       (stride_o),
    .loop_counter_o (loop_counter_o)
  );

  // Inputs only change #1 after posedge, so the negedge view predicts the next edge.
  always @(negedge clk_i) if (!reset_i && v_o && ready_and_i) xfers++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ld(input logic [VW-1:0] pc, input logic [VW-1:0] addr);
    load_v_i        = 1'b1;
    load_pc_i       = pc;
    load_eff_addr_i = addr;
    tick();
    load_v_i        = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [VW-1:0] pc,
                         input logic [VW-1:0] addr, input logic [7:0] stride);
    chk({tag, "_v"},      64'(v_o),            64'd1);
    chk({tag, "_pc"},     64'(pc_o),           64'(pc));
    chk({tag, "_addr"},   64'(eff_addr_o),     64'(addr));
    chk({tag, "_stride"}, 64'(stride_o),       64'(stride));
    chk({tag, "_lc"},     64'(loop_counter_o), 64'd4);
  endtask

  initial begin
    reset_i = 1'b1; load_v_i = 1'b0; ready_and_i = 1'b1;
    load_pc_i = '0; load_eff_addr_i = '0;
    tick(); tick();
    chk("rst_v",      64'(v_o),            64'd0);
    chk("rst_pc",     64'(pc_o),           64'd0);
    chk("rst_addr",   64'(eff_addr_o),     64'd0);
    chk("rst_stride", 64'(stride_o),       64'd0);
    chk("rst_lc",     64'(loop_counter_o), 64'd4);
    reset_i = 1'b0;

    // confirm stride 8 on PC 0x100
    base = xfers;
    for (int i = 0; i < 3; i++) begin
      ld(39'h100, 39'h1000 + 39'(8*i));
      chk("t1_early_v", 64'(v_o), 64'd0);
    end
    ld(39'h100, 39'h1018);
    chk_req("t1", 39'h100, 39'h1018, 8'd8);

    // quiet window: 4 silent loads, fifth triggers
    for (int i = 0; i < 4; i++) begin
      ld(39'h100, 39'h1020 + 39'(8*i));
      chk("t2_quiet_v", 64'(v_o), 64'd0);
    end
    chk("t2_xfers_a", 64'(xfers), 64'(base + 1));
    ld(39'h100, 39'h1040);
    chk_req("t2", 39'h100, 39'h1040, 8'd8);
    tick();
    chk("t2_xfers_b", 64'(xfers), 64'(base + 2));

    // back-pressure: held request, second trigger dropped
    ready_and_i = 1'b0;
    for (int i = 0; i < 4; i++) ld(39'h104, 39'h3000 + 39'(4*i));
    chk_req("t3_held", 39'h104, 39'h300C, 8'd4);
    for (int i = 0; i < 4; i++) ld(39'h200, 39'h6000 + 39'(16*i));
    chk_req("t3_stable", 39'h104, 39'h300C, 8'd4);
    base = xfers;
    ready_and_i = 1'b1;
    tick();
    ready_and_i = 1'b0;
    chk("t3_drain_v", 64'(v_o), 64'd0);
    chk("t3_one_xfer", 64'(xfers), 64'(base + 1));
    tick(); tick();
    chk("t3_no_more", 64'(xfers), 64'(base + 1));
    ready_and_i = 1'b1;
    ld(39'h200, 39'h6040);
    chk_req("t3_noquiet", 39'h200, 39'h6040, 8'h10);
    tick();

    // ineligible strides, then largest eligible stride
    base = xfers;
    for (int i = 0; i < 6; i++) begin
      ld(39'h108, 39'h2000 - 39'(8*i));
      chk("t4_neg_v", 64'(v_o), 64'd0);
    end
    for (int i = 0; i < 6; i++) begin
      ld(39'h10C, 39'h4000 + 39'(512*i));
      chk("t4_big_v", 64'(v_o), 64'd0);
    end
    chk("t4_xfers", 64'(xfers), 64'(base));
    for (int i = 0; i < 4; i++) ld(39'h114, 39'h7000 + 39'(255*i));
    chk_req("t4_ff", 39'h114, 39'h72FD, 8'hFF);
    tick();

    // aliasing PCs, then stride change 8 -> 16
    base = xfers;
    for (int i = 0; i < 8; i++) begin
      ld((i % 2) ? 39'h200 : 39'h100, 39'h8000 + 39'(8*(i/2)) + 39'((i % 2)*4096));
      chk("t5_alias_v", 64'(v_o), 64'd0);
    end
    ld(39'h110, 39'h5000); chk("t5_v0", 64'(v_o), 64'd0);
    ld(39'h110, 39'h5008); chk("t5_v1", 64'(v_o), 64'd0);
    ld(39'h110, 39'h5010); chk("t5_v2", 64'(v_o), 64'd0);
    ld(39'h110, 39'h5020); chk("t5_v3", 64'(v_o), 64'd0);
    ld(39'h110, 39'h5030); chk("t5_v4", 64'(v_o), 64'd0);
    ld(39'h110, 39'h5040);
    chk_req("t5", 39'h110, 39'h5040, 8'h10);
    chk("t5_xfers", 64'(xfers), 64'(base));
    tick();

    // reset with a pending request
    ready_and_i = 1'b0;
    for (int i = 0; i < 4; i++) ld(39'h118, 39'h9000 + 39'(8*i));
    chk_req("t6_pend", 39'h118, 39'h9018, 8'd8);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    ready_and_i = 1'b1;
    chk("t6_rst_v",    64'(v_o),        64'd0);
    chk("t6_rst_addr", 64'(eff_addr_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      ld(39'h118, 39'h9020 + 39'(8*i));
      chk("t6_cold_v", 64'(v_o), 64'd0);
    end
    ld(39'h118, 39'h9038);
    chk_req("t6", 39'h118, 39'h9038, 8'd8);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
